// File: rtl/prog_clock_divider.sv
// Programmable clock divider / clock-enable generator.
// Emits a one-cycle tick every DIV_eff cycles and a 50%-duty clock_out of period 2*DIV_eff.
// A new divisor is held pending and applied only at a period boundary or while counting is frozen.
module prog_clock_divider #(
  parameter int unsigned WIDTH       = 20,
  parameter int unsigned DEFAULT_DIV = 2**19
) (
  input  logic             clock_in,
  input  logic             rst,
  input  logic             en,
  input  logic             clr,
  input  logic [WIDTH-1:0] div_in,
  input  logic             div_load,
  output logic             div_busy,
  output logic             tick,
  output logic             clock_out
);

  localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
  localparam logic [WIDTH-1:0] RESET_DIV = (DEFAULT_DIV == 0) ? ONE : WIDTH'(DEFAULT_DIV);

  logic [WIDTH-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [WIDTH-1:0] pend_val_q, pend_val_d;
  logic             div_busy_q, div_busy_d;
  logic             tick_q, tick_d;
  logic             clock_out_q, clock_out_d;

  logic [WIDTH-1:0] div_eff_c;
  logic [WIDTH-1:0] load_val_c;
  logic             wrap_c;
  logic             apply_c;

  // Effective divisor, sanitised load value and boundary detection (cnt beyond range also wraps)
  always_comb begin
    div_eff_c  = (div_q == '0) ? ONE : div_q;
    load_val_c = (div_in == '0) ? ONE : div_in;
    wrap_c     = (cnt_q >= (div_eff_c - ONE));
    apply_c    = !clr && (!en || wrap_c);
  end

  // Next-state: clr beats divisor apply, which beats ordinary counting
  always_comb begin
    cnt_d       = cnt_q;
    div_d       = div_q;
    pend_val_d  = pend_val_q;
    div_busy_d  = div_busy_q;
    tick_d      = 1'b0;
    clock_out_d = clock_out_q;

    if (clr) begin
      cnt_d       = '0;
      clock_out_d = 1'b0;
      if (div_load) begin
        pend_val_d = load_val_c;
        div_busy_d = 1'b1;
      end
    end else begin
      if (apply_c) begin
        if (div_load) begin
          div_d      = load_val_c;
          div_busy_d = 1'b0;
        end else if (div_busy_q) begin
          div_d      = pend_val_q;
          div_busy_d = 1'b0;
        end
        if (!en && (div_load || div_busy_q)) begin
          cnt_d = '0;
        end
      end else if (div_load) begin
        pend_val_d = load_val_c;
        div_busy_d = 1'b1;
      end

      if (en) begin
        if (wrap_c) begin
          cnt_d       = '0;
          tick_d      = 1'b1;
          clock_out_d = ~clock_out_q;
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    end
  end

  // State registers, asynchronously cleared
  always_ff @(posedge clock_in or negedge rst) begin
    if (!rst) begin
      cnt_q       <= '0;
      div_q       <= RESET_DIV;
      pend_val_q  <= RESET_DIV;
      div_busy_q  <= 1'b0;
      tick_q      <= 1'b0;
      clock_out_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      div_q       <= div_d;
      pend_val_q  <= pend_val_d;
      div_busy_q  <= div_busy_d;
      tick_q      <= tick_d;
      clock_out_q <= clock_out_d;
    end
  end

  assign div_busy  = div_busy_q;
  assign tick      = tick_q;
  assign clock_out = clock_out_q;

endmodule

// File: tb/tb_prog_clock_divider.sv
// Directed bench for prog_clock_divider with DEFAULT_DIV=4, WIDTH=8.
module tb_prog_clock_divider;

  localparam int unsigned W = 8;

  logic         clk;
  logic         rst;
  logic         en;
  logic         clr;
  logic [W-1:0] div_in;
  logic         div_load;
  logic         div_busy;
  logic         tick;
  logic         clock_out;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic         en;
    logic         clr;
    logic         ld;
    logic [W-1:0] din;
    logic         tick;
    logic         clk_o;
    logic         busy;
  } vec_t;

  vec_t vecs[$];

  prog_clock_divider #(.WIDTH(W), .DEFAULT_DIV(4)) dut (
    .clock_in (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .div_in   (div_in),
    .div_load (div_load),
    .div_busy (div_busy),
    .tick     (tick),
    .clock_out(clock_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic addv(input logic e, input logic c, input logic l, input logic [W-1:0] d,
                      input logic t, input logic co, input logic b);
    vec_t v;
    v.en = e; v.clr = c; v.ld = l; v.din = d; v.tick = t; v.clk_o = co; v.busy = b;
    vecs.push_back(v);
  endtask

  // Drive inputs, take one rising edge, settle 1 time unit past it
  task automatic step(input logic e, input logic c, input logic l, input logic [W-1:0] d);
    en = e; clr = c; div_load = l; div_in = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; en = 1'b0; clr = 1'b0; div_load = 1'b0; div_in = '0;

    // Edges 1..40 after reset release: divisor 4, load 3, load 0, direct load 2, last-wins 7->3
    for (int i = 1; i <= 3; i++) addv(1, 0, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 1, 1, 0);                                // 4
    for (int i = 5; i <= 7; i++) addv(1, 0, 0, 0, 0, 1, 0);
    addv(1, 0, 0, 0, 1, 0, 0);                                // 8
    addv(1, 0, 0, 0, 0, 0, 0);                                // 9
    addv(1, 0, 1, 3, 0, 0, 1);                                // 10 load 3
    addv(1, 0, 0, 0, 0, 0, 1);                                // 11
    addv(1, 0, 0, 0, 1, 1, 0);                                // 12 apply
    addv(1, 0, 0, 0, 0, 1, 0);
    addv(1, 0, 0, 0, 0, 1, 0);
    addv(1, 0, 0, 0, 1, 0, 0);                                // 15
    addv(1, 0, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 1, 1, 0);                                // 18
    addv(1, 0, 1, 0, 0, 1, 1);                                // 19 load 0
    addv(1, 0, 0, 0, 0, 1, 1);
    addv(1, 0, 0, 0, 1, 0, 0);                                // 21 apply -> div 1
    addv(1, 0, 0, 0, 1, 1, 0);
    addv(1, 0, 0, 0, 1, 0, 0);
    addv(1, 0, 0, 0, 1, 1, 0);                                // 24
    addv(1, 0, 1, 2, 1, 0, 0);                                // 25 load on wrap edge
    addv(1, 0, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 1, 1, 0);                                // 27
    addv(1, 0, 1, 5, 0, 1, 1);                                // 28 load 5
    addv(1, 0, 0, 0, 1, 0, 0);                                // 29 apply 5
    addv(1, 0, 1, 7, 0, 0, 1);                                // 30 load 7
    addv(1, 0, 1, 3, 0, 0, 1);                                // 31 overwrite with 3
    addv(1, 0, 0, 0, 0, 0, 1);
    addv(1, 0, 0, 0, 0, 0, 1);
    addv(1, 0, 0, 0, 1, 1, 0);                                // 34 apply 3
    addv(1, 0, 0, 0, 0, 1, 0);
    addv(1, 0, 0, 0, 0, 1, 0);
    addv(1, 0, 0, 0, 1, 0, 0);                                // 37
    addv(1, 0, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 0, 0, 0);
    addv(1, 0, 0, 0, 1, 1, 0);                                // 40

    #12;
    chk("reset tick", 32'(tick), 32'd0);
    chk("reset clock_out", 32'(clock_out), 32'd0);
    chk("reset busy", 32'(div_busy), 32'd0);
    chk("reset div_q", 32'(dut.div_q), 32'd4);
    chk("reset cnt", 32'(dut.cnt_q), 32'd0);

    @(negedge clk);
    rst = 1'b1;

    foreach (vecs[i]) begin
      step(vecs[i].en, vecs[i].clr, vecs[i].ld, vecs[i].din);
      chk($sformatf("edge%0d tick", i + 1), 32'(tick), 32'(vecs[i].tick));
      chk($sformatf("edge%0d clock_out", i + 1), 32'(clock_out), 32'(vecs[i].clk_o));
      chk($sformatf("edge%0d busy", i + 1), 32'(div_busy), 32'(vecs[i].busy));
    end

    // Freeze at cnt=2 (div 3), then load 6 while frozen
    step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("pre-hold cnt", 32'(dut.cnt_q), 32'd2);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 0, 0);
      chk($sformatf("hold%0d cnt", i), 32'(dut.cnt_q), 32'd2);
      chk($sformatf("hold%0d tick", i), 32'(tick), 32'd0);
      chk($sformatf("hold%0d clock_out", i), 32'(clock_out), 32'd1);
    end
    step(0, 0, 1, 6);
    chk("frozen load busy", 32'(div_busy), 32'd0);
    chk("frozen load cnt", 32'(dut.cnt_q), 32'd0);
    chk("frozen load div_q", 32'(dut.div_q), 32'd6);
    for (int i = 0; i < 5; i++) begin
      step(1, 0, 0, 0);
      chk($sformatf("div6 early%0d tick", i), 32'(tick), 32'd0);
    end
    step(1, 0, 0, 0);
    chk("div6 tick", 32'(tick), 32'd1);
    chk("div6 clock_out", 32'(clock_out), 32'd0);

    // Pending divisor applied by dropping en mid-period
    step(1, 0, 1, 2);
    chk("pend2 busy", 32'(div_busy), 32'd1);
    step(0, 0, 0, 0);
    chk("en0 apply busy", 32'(div_busy), 32'd0);
    chk("en0 apply cnt", 32'(dut.cnt_q), 32'd0);
    chk("en0 apply tick", 32'(tick), 32'd0);
    step(1, 0, 0, 0);
    chk("div2 early tick", 32'(tick), 32'd0);
    step(1, 0, 0, 0);
    chk("div2 tick", 32'(tick), 32'd1);
    chk("div2 clock_out", 32'(clock_out), 32'd1);

    // Move to div 8 with clock_out high, then clr at cnt=3
    step(1, 0, 1, 8);
    chk("pend8 busy", 32'(div_busy), 32'd1);
    step(1, 0, 0, 0);
    chk("apply8 tick", 32'(tick), 32'd1);
    chk("apply8 busy", 32'(div_busy), 32'd0);
    for (int i = 0; i < 7; i++) step(1, 0, 0, 0);
    step(1, 0, 0, 0);
    chk("div8 tick", 32'(tick), 32'd1);
    chk("div8 clock_out", 32'(clock_out), 32'd1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0);
    chk("pre-clr cnt", 32'(dut.cnt_q), 32'd3);
    step(1, 1, 0, 0);
    chk("clr cnt", 32'(dut.cnt_q), 32'd0);
    chk("clr clock_out", 32'(clock_out), 32'd0);
    chk("clr tick", 32'(tick), 32'd0);
    for (int i = 0; i < 7; i++) begin
      step(1, 0, 0, 0);
      chk($sformatf("post-clr%0d tick", i), 32'(tick), 32'd0);
    end
    step(1, 0, 0, 0);
    chk("post-clr tick", 32'(tick), 32'd1);
    chk("post-clr clock_out", 32'(clock_out), 32'd1);

    // Async reset mid-period with a divisor pending
    step(1, 0, 1, 3);
    chk("pre-rst busy", 32'(div_busy), 32'd1);
    div_load = 1'b0;
    #2;
    rst = 1'b0;
    #1;
    chk("async rst clock_out", 32'(clock_out), 32'd0);
    chk("async rst busy", 32'(div_busy), 32'd0);
    chk("async rst tick", 32'(tick), 32'd0);
    chk("async rst div_q", 32'(dut.div_q), 32'd4);
    @(negedge clk);
    rst = 1'b1;
    for (int e = 1; e <= 8; e++) begin
      step(1, 0, 0, 0);
      chk($sformatf("rerun edge%0d tick", e), 32'(tick), 32'((e % 4) == 0));
      chk($sformatf("rerun edge%0d clock_out", e), 32'(clock_out), 32'(e >= 4 && e < 8));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
